// File: rtl/dog_sequencer.sv
// Octave-level controller for the shared dog core: launches one core pass per adjacent
// blur pair, steers the blur/DoG BRAM selects and registers the core output as DoG writes.
module dog_sequencer #(
    parameter  int DIMENSION = 64,
    parameter  int NUM_BLURS = 4,
    localparam int ADDR_W    = $clog2(DIMENSION * DIMENSION),
    localparam int LVL_W     = (NUM_BLURS > 2) ? $clog2(NUM_BLURS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic                     err_count,
    output logic                     dog_start,
    input  logic                     dog_busy,
    input  logic                     dog_valid,
    input  logic [ADDR_W-1:0]        dog_address,
    input  logic signed [8:0]        dog_data,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [LVL_W-1:0]         sharper_sel,
    output logic [LVL_W-1:0]         fuzzier_sel,
    output logic                     wr_en,
    output logic [LVL_W-1:0]         wr_sel,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [8:0]        wr_data,
    output logic [LVL_W-1:0]         level
);

    localparam int                PIX       = DIMENSION * DIMENSION;
    localparam int                CNT_W     = $clog2(PIX + 1);
    localparam logic [CNT_W-1:0]  PIX_C     = CNT_W'(PIX);
    localparam logic [LVL_W-1:0]  LAST_LVL  = LVL_W'(NUM_BLURS - 2);
    localparam logic [3:0]        WAIT_LAST = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_DRAIN, S_NEXT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [CNT_W-1:0]    pix_q, pix_d;
    logic [3:0]          wait_q, wait_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_count_q, err_count_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic signed [8:0]   wr_data_q, wr_data_d;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of its peers regardless of process ordering.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            level_q       <= '0;
            pix_q         <= '0;
            wait_q        <= '0;
            err_timeout_q <= 1'b0;
            err_count_q   <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            pix_q         <= pix_d;
            wait_q        <= wait_d;
            err_timeout_q <= err_timeout_d;
            err_count_q   <= err_count_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        pix_d         = pix_q;
        wait_d        = wait_q;
        err_timeout_d = err_timeout_q;
        err_count_d   = err_count_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;

        unique case (state_q)
            S_IDLE: if (start) begin
                state_d       = S_LAUNCH;
                level_d       = '0;
                pix_d         = '0;
                err_timeout_d = 1'b0;
                err_count_d   = 1'b0;
            end
            S_LAUNCH: begin
                wait_d  = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (dog_busy) begin
                    state_d = S_RUN;
                end else if (wait_q == WAIT_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_RUN: begin
                if (dog_valid && dog_busy) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = dog_address;
                    wr_data_d = dog_data;
                    if (pix_q != PIX_C) pix_d = pix_q + CNT_W'(1);
                end
                if (!dog_busy) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pix_q != PIX_C) err_count_d = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (level_q == LAST_LVL) begin
                    state_d = S_DONE;
                end else begin
                    level_d = level_q + LVL_W'(1);
                    pix_d   = '0;
                    state_d = S_LAUNCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort leaves the error flags exactly as they were before this cycle.
        if (abort && state_q != S_IDLE) begin
            state_d       = S_IDLE;
            wr_en_d       = 1'b0;
            err_timeout_d = err_timeout_q;
            err_count_d   = err_count_q;
        end
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE) && !err_timeout_q && !abort;
        dog_start   = (state_q == S_LAUNCH);
        err_timeout = err_timeout_q;
        err_count   = err_count_q;
        rd_addr     = dog_address;
        sharper_sel = level_q;
        fuzzier_sel = busy ? (level_q + LVL_W'(1)) : '0;
        wr_sel      = level_q;
        level       = level_q;
        wr_en       = wr_en_q && !(abort && busy);
        wr_addr     = wr_addr_q;
        wr_data     = wr_data_q;
    end

endmodule

// File: tb/tb_dog_sequencer.sv
// Scoreboard bench for dog_sequencer at DIMENSION=4, NUM_BLURS=4 with a directed model core;
// a negedge monitor pops expected writes and launches as the DUT presents them.
module tb_dog_sequencer;

    localparam int DIM = 4;
    localparam int NB  = 4;
    localparam int PIX = DIM * DIM;
    localparam int AW  = 4;
    localparam int LW  = 2;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          start, abort;
    logic          busy, done, err_timeout, err_count, dog_start;
    logic          dog_busy, dog_valid;
    logic [AW-1:0] dog_address;
    logic [8:0]    dog_data;
    logic [AW-1:0] rd_addr;
    logic [LW-1:0] sharper_sel, fuzzier_sel, wr_sel, level;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [8:0]    wr_data;

    dog_sequencer #(.DIMENSION(DIM), .NUM_BLURS(NB)) dut (
        .clk(clk), .rst_in(rst_in), .start(start), .abort(abort),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_count(err_count),
        .dog_start(dog_start), .dog_busy(dog_busy), .dog_valid(dog_valid),
        .dog_address(dog_address), .dog_data(dog_data), .rd_addr(rd_addr),
        .sharper_sel(sharper_sel), .fuzzier_sel(fuzzier_sel), .wr_en(wr_en),
        .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] sel;
        logic [AW-1:0] addr;
        logic [8:0]    data;
        int            stamp;
    } wr_t;

    wr_t sb[$];
    int  lq[$];
    int  tests = 0, failed = 0;
    int  cyc = 0, n_starts = 0, n_done = 0, n_writes = 0, exp_writes = 0;
    int  last_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core difference output per level/address, with a few hand-picked corner values.
    function automatic logic [8:0] data_for(input int lvl, input int a);
        int v;
        if (a == 5 && lvl == 0)       v = 42 - 23;
        else if (a == 5 && lvl == 1)  v = 42 - 63;
        else if (a == 15 && lvl == 0) v = 255;
        else if (a == 0 && lvl == 2)  v = -256;
        else                          v = a * 3 - lvl * 50;
        return v[8:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_in) begin
            if (wr_en) begin
                n_writes++;
                if (sb.size() == 0) begin
                    tests++; failed++;
                    $display("FAIL unexpected_write: got sel=%0d addr=%0d data=0x%0h, expected none",
                             wr_sel, wr_addr, wr_data);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_sel", 32'(wr_sel), 32'(e.sel));
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                    check("wr_latency", cyc, e.stamp);
                end
            end
            if (dog_start) begin
                n_starts++;
                if (lq.size() == 0) begin
                    tests++; failed++;
                    $display("FAIL unexpected_dog_start: got level=%0d, expected none", level);
                end else begin
                    int l;
                    l = lq.pop_front();
                    check("launch_level", 32'(level), l);
                    check("launch_sharper", 32'(sharper_sel), l);
                    check("launch_fuzzier", 32'(fuzzier_sel), l + 1);
                    check("launch_wr_sel", 32'(wr_sel), l);
                end
            end
            if (done) n_done++;
        end
    end

    // Model core: waits for dog_start, raises busy, emits n_valid pixels, drops busy.
    // abort_at >= 1 aborts the sequencer in place of pixel abort_at.
    task automatic core_level(input int lvl, input int n_valid, input int abort_at, input bit hold_start);
        int  w;
        bit  ok;
        w  = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (dog_start) begin ok = 1; break; end
            tick();
            w++;
        end
        last_wait = w;
        if (!ok) begin
            check("dog_start_seen", 32'(dog_start), 1);
            return;
        end
        tick();
        dog_busy    = 1'b1;
        dog_valid   = 1'b1;
        dog_address = 4'd15;
        dog_data    = 9'h0AA;
        if (hold_start) start = 1'b1;
        tick();
        for (int i = 0; i < n_valid; i++) begin
            int a;
            a = (i * 5) % PIX;
            if (i == abort_at) begin
                sb.pop_back();
                exp_writes--;
                abort     = 1'b1;
                dog_valid = 1'b1;
                #1;
                check("wr_en_abort_cycle", 32'(wr_en), 0);
                tick();
                abort     = 1'b0;
                dog_valid = 1'b0;
                dog_busy  = 1'b0;
                start     = 1'b0;
                return;
            end
            dog_valid   = 1'b1;
            dog_address = a[AW-1:0];
            dog_data    = data_for(lvl, a);
            sb.push_back('{sel: lvl[LW-1:0], addr: a[AW-1:0], data: data_for(lvl, a), stamp: cyc + 1});
            exp_writes++;
            tick();
        end
        dog_valid = 1'b0;
        dog_busy  = 1'b0;
        start     = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_errs"}, 32'({err_timeout, err_count}), 0);
        check({tag, "_dog_start"}, 32'(dog_start), 0);
        check({tag, "_wr"}, 32'({wr_en, wr_addr, wr_data}), 0);
        check({tag, "_sels"}, 32'({sharper_sel, fuzzier_sel, wr_sel, level}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_in = 1'b1; start = 1'b0; abort = 1'b0;
        dog_busy = 1'b0; dog_valid = 1'b0; dog_address = '0; dog_data = '0;
        #3;
        check_all_zero("reset");
        tick(); tick();
        rst_in = 1'b0;
        tick();

        // Nominal octave with start held high during level 0.
        d0 = n_done;
        lq.push_back(0); lq.push_back(1); lq.push_back(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        core_level(0, 16, -1, 1'b1);
        check("start_to_dog_start", last_wait, 0);
        core_level(1, 16, -1, 1'b0);
        check("level_gap", last_wait, 2);
        core_level(2, 16, -1, 1'b0);
        check("level_gap2", last_wait, 2);
        tick(); tick();
        check("nom_done", 32'(done), 1);
        check("nom_busy_at_done", 32'(busy), 1);
        check("nom_errs", 32'({err_timeout, err_count}), 0);
        tick();
        check("nom_idle", 32'({busy, done}), 0);
        check("nom_done_count", n_done - d0, 1);
        check("nom_writes", n_writes, 48);

        // Core never raises busy.
        d0 = n_done;
        lq.push_back(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_dog_start", 32'(dog_start), 1);
        tick();
        for (int k = 0; k < 15; k++) tick();
        check("to_flag_early", 32'(err_timeout), 0);
        tick();
        check("to_flag", 32'(err_timeout), 1);
        check("to_no_done", 32'(done), 0);
        begin
            int k;
            for (k = 0; k < 2 && busy; k++) tick();
            check("to_busy_falls", 32'(busy), 0);
        end
        check("to_done_count", n_done - d0, 0);

        // Short level 1; flags cleared by the accepted start.
        d0 = n_done;
        lq.push_back(0); lq.push_back(1); lq.push_back(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("short_timeout_cleared", 32'(err_timeout), 0);
        core_level(0, 16, -1, 1'b0);
        core_level(1, 15, -1, 1'b0);
        check("short_count_in_drain", 32'(err_count), 0);
        tick();
        check("short_count_after_drain", 32'(err_count), 1);
        core_level(2, 16, -1, 1'b0);
        tick(); tick();
        check("short_done", 32'(done), 1);
        check("short_count_held", 32'(err_count), 1);
        tick();
        check("short_done_count", n_done - d0, 1);

        // Abort during level 1 RUN; dog_valid outside RUN afterwards.
        d0 = n_done;
        lq.push_back(0); lq.push_back(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_count_cleared", 32'(err_count), 0);
        core_level(0, 16, -1, 1'b0);
        core_level(1, 16, 4, 1'b0);
        check("abort_idle", 32'({busy, done, wr_en}), 0);
        dog_valid = 1'b1;
        dog_address = 4'd3;
        for (int k = 0; k < 3; k++) tick();
        dog_valid = 1'b0;
        check("abort_done_count", n_done - d0, 0);

        // start and abort together in IDLE, then abort in LAUNCH.
        lq.push_back(0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_wins", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_launch", 32'(busy), 0);

        // Asynchronous reset mid-RUN with a write in flight.
        d0 = n_done;
        lq.push_back(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dog_busy = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            dog_valid   = 1'b1;
            dog_address = AW'(i * 5);
            dog_data    = data_for(0, i * 5);
            sb.push_back('{sel: '0, addr: AW'(i * 5), data: data_for(0, i * 5), stamp: cyc + 1});
            exp_writes++;
            tick();
        end
        dog_valid = 1'b0;
        #1;
        rst_in = 1'b1;
        sb.pop_back();
        exp_writes--;
        #1;
        check_all_zero("async_rst");
        dog_busy = 1'b0;
        tick(); tick();
        rst_in = 1'b0;
        tick(); tick();
        check("rst_done_count", n_done - d0, 0);

        check("sb_empty", sb.size(), 0);
        check("launch_q_empty", lq.size(), 0);
        check("total_starts", n_starts, 11);
        check("total_writes", n_writes, exp_writes);
        check("total_done", n_done, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dog_sequencer.md
# dog_sequencer

Controller that builds a full difference-of-Gaussians stack for one octave by running the shared `dog` core once per adjacent blur pair. On `start` it steps the level index from 0 to NUM_BLURS-2. For each level it selects the sharper/fuzzier blur BRAMs, pulses the core's start input, forwards the core's read address, and writes the core's signed output into the matching DoG BRAM. It sits between the blur-pyramid BRAM bank and the DoG BRAM bank, upstream of keypoint extraction.

## Interface
- DIMENSION, 64: image side length; one level is DIMENSION*DIMENSION pixels.
- NUM_BLURS, 4: blurred images per octave (≥2); produces NUM_BLURS-1 DoG images.
- Derived: ADDR_W = $clog2(DIMENSION*DIMENSION); LVL_W = max(1,$clog2(NUM_BLURS)).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- start  in  1  request one octave build; sampled only in IDLE.
- abort  in  1  cancel the build in progress.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err_timeout  out  1  sticky; core never raised busy; cleared on accepted start.
- err_count  out  1  sticky; level write count ≠ DIMENSION²; cleared on accepted start.
- dog_start  out  1  one-cycle launch pulse to core (`bram_ready`).
- dog_busy  in  1  core busy.
- dog_valid  in  1  core data_out/address valid this cycle.
- dog_address  in  ADDR_W  core pixel address.
- dog_data  in  9 signed  core difference output.
- rd_addr  out  ADDR_W  address to both selected blur BRAMs.
- sharper_sel  out  LVL_W  blur BRAM feeding core sharper_pix (= level).
- fuzzier_sel  out  LVL_W  blur BRAM feeding core fuzzier_pix (= level+1).
- wr_en  out  1  DoG BRAM write enable.
- wr_sel  out  LVL_W  DoG BRAM index (= level).
- wr_addr  out  ADDR_W  DoG write address.
- wr_data  out  9 signed  DoG write data.
- level  out  LVL_W  current pair index.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, RUN, DRAIN, NEXT, DONE.
- IDLE + start=1 → LAUNCH; level←0; pix_count←0; both error flags cleared.
- LAUNCH: dog_start=1 for this cycle only; wait counter←0 → WAIT_BUSY.
- WAIT_BUSY: dog_busy=1 → RUN. Otherwise the wait counter increments. If 16 cycles pass without dog_busy → err_timeout←1 → DONE.
- RUN: each cycle with dog_valid & dog_busy registers one write (see Timing) and increments pix_count, saturating at DIMENSION². dog_busy=0 → DRAIN.
- DRAIN: last registered write retires. If pix_count ≠ DIMENSION², err_count←1 → NEXT.
- NEXT: if level = NUM_BLURS-2 → DONE; else level+1, pix_count←0 → LAUNCH.
- DONE: done=1 only if err_timeout=0 → IDLE. err_count does not suppress done.
- abort=1 in any non-IDLE state → IDLE next cycle. No done. wr_en forced 0 that cycle. Error flags are held.
- sharper_sel, fuzzier_sel, and wr_sel are stable from LAUNCH through NEXT of a level.
- rd_addr = dog_address combinationally. Blur BRAM latency is owned by the core.
- wr_data copies dog_data bit-exactly; no saturation or reformatting.

## Timing
- Reset values: state IDLE. All outputs 0: busy, done, errors, dog_start, wr_en, wr_addr, wr_data, selects, level.
- start→dog_start: 1 cycle (start sampled edge N, dog_start high during cycle N+1).
- Write latency 1 cycle: dog_valid at edge N → wr_en/wr_addr/wr_data valid during cycle N+1, single-cycle wr_en per valid.
- Level-to-level gap: DRAIN + NEXT + LAUNCH = 3 cycles between dog_busy falling and the next dog_start.
- done asserts 1 cycle after NEXT of the final level; busy falls on the same edge as done falls.
- start while busy: ignored, no effect on counters or flags.
- start and abort together in IDLE: start wins (abort meaningless in IDLE).
- dog_valid outside RUN: ignored, no write.
- Reset mid-operation: all state and outputs return to reset values immediately (asynchronous). Any write in flight is dropped.

## Test plan
- Nominal, DIMENSION=4, NUM_BLURS=4: one start, model core emits 16 valids per launch. Required: 3 dog_start pulses; levels 0,1,2; 48 writes with wr_sel 0,1,2 × 16; sharper/fuzzier pairs (0,1),(1,2),(2,3); single done; no errors.
- Data path: core returns dog_data = +42-23 = 19 then 42-63 = -21 at address 5. Required: wr_addr=5 with wr_data 19 then -21 (9'h1EB), each one cycle after dog_valid.
- Timeout: model core never raises dog_busy. Required: err_timeout=1 exactly 16 cycles after WAIT_BUSY entry; no done; busy low 2 cycles later; only 1 dog_start.
- Short level: core emits 15 valids on level 1. Required: err_count=1 after level 1 DRAIN; levels 2 still runs; done pulses; next start clears err_count.
- Abort and reset: abort during level 1 RUN → IDLE next cycle, no done, no further wr_en. Separately, async rst_in mid-RUN → all outputs 0 before the next clock edge.
- start while busy: repeated start pulses during level 0 → no extra dog_start and counts unchanged.
